// File: rtl/posit_add_arbiter_pkg.sv
// Shared constants and types for the posit adder arbiter.
package posit_add_arbiter_pkg;

  // Posit format carried through the block (contents are never inspected)
  localparam int NBITS = 32;
  localparam int ES    = 2;

  // Requester index width large enough for the largest supported NREQ (8)
  localparam int NREQ_MAX  = 8;
  localparam int TAG_IDX_W = $clog2(NREQ_MAX);

  // One entry of the shadow tag pipeline that follows the adder
  typedef struct packed {
    logic                 vld;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/posit_add_arbiter_rr_arbiter.sv
// Round-robin arbiter: NREQ requests in, one-hot grant out, pointer kept inside.
// Optional build macro POSIT_ARB_FIXED_PRIO_EN gives requester 0 strict priority;
// requesters 1..NREQ-1 then rotate among themselves.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  // Search for the first eligible requester after the pointer and pick the next pointer
  always_comb begin
    int  cand;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    cand    = 0;
`ifdef POSIT_ARB_FIXED_PRIO_EN
    if (req[0]) begin
      // Requester 0 wins outright and leaves the rotation untouched
      gnt[0]  = 1'b1;
      gnt_any = 1'b1;
      found   = 1'b1;
    end else begin
      // Rotation over 1..NREQ-1; pointer always lives in that range
      for (int k = 1; k < NREQ; k++) begin
        cand = int'(ptr_q) + k;
        if (cand > NREQ - 1) cand = cand - (NREQ - 1);
        if (!found && req[cand]) begin
          found         = 1'b1;
          gnt[cand]     = 1'b1;
          gnt_idx       = IDX_W'(cand);
          gnt_any       = 1'b1;
          ptr_d         = IDX_W'(cand);
        end
      end
    end
`else
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = IDX_W'(cand);
        gnt_any   = 1'b1;
        ptr_d     = IDX_W'(cand);
      end
    end
`endif
  end

  // Pointer register; reset to the last requester so requester 0 is searched first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= IDX_W'(NREQ - 1);
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/posit_add_arbiter.sv
// Shares one fixed-latency pipelined posit adder among NREQ requesters.
// Round-robin issue, shadow tag pipeline for result routing, per-requester credits.
// Optional build macro POSIT_ARB_FIXED_PRIO_EN (handled in rr_arbiter): requester 0
// gets strict priority.
module posit_add_arbiter
  import posit_add_arbiter_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int ADD_LATENCY = 4,
  parameter int MAX_OUT     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*NBITS-1:0] req_a,
  input  logic [NREQ*NBITS-1:0] req_b,
  output logic                  add_valid,
  output logic [NBITS-1:0]      add_a,
  output logic [NBITS-1:0]      add_b,
  input  logic [NBITS-1:0]      add_result,
  output logic [NREQ-1:0]       res_valid,
  output logic [NBITS-1:0]      res_data,
  output logic                  busy
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;

  logic             add_valid_q, add_valid_d;
  logic [NBITS-1:0] add_a_q, add_a_d;
  logic [NBITS-1:0] add_b_q, add_b_d;
  logic [IDX_W-1:0] add_idx_q, add_idx_d;

  tag_t             tag_q [ADD_LATENCY];
  tag_t             tag_d [ADD_LATENCY];

  logic [NREQ-1:0]  ret_vec;
  logic [NREQ-1:0]  res_valid_q, res_valid_d;
  logic [NBITS-1:0] res_data_q, res_data_d;

  logic [CNT_W-1:0] cnt_q [NREQ];
  logic [CNT_W-1:0] cnt_d [NREQ];

  // A requester may compete only while it holds a free credit
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUT));
    end
  end

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (elig),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign req_ready = gnt;

  // Issue register: capture the winner's operands; operands hold when idle
  always_comb begin
    add_valid_d = gnt_any;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_idx_d   = add_idx_q;
    if (gnt_any) begin
      add_a_d   = req_a[int'(gnt_idx)*NBITS +: NBITS];
      add_b_d   = req_b[int'(gnt_idx)*NBITS +: NBITS];
      add_idx_d = gnt_idx;
    end
  end

  // Tag pipeline fed from the issue register; its last stage lines up with add_result
  always_comb begin
    tag_d[0].vld = add_valid_q;
    tag_d[0].idx = TAG_IDX_W'(add_idx_q);
    for (int s = 1; s < ADD_LATENCY; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  // Decode the returning tag and build the registered result outputs
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      ret_vec[i] = tag_q[ADD_LATENCY-1].vld &&
                   (tag_q[ADD_LATENCY-1].idx == TAG_IDX_W'(i));
    end
    res_valid_d = ret_vec;
    res_data_d  = add_result;
  end

  // Credits: +1 on grant, -1 when the result is handed back, unchanged when both
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (gnt[i] && !ret_vec[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (!gnt[i] && ret_vec[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  // Busy while any requester still has an operation outstanding
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (cnt_q[i] != '0) busy = 1'b1;
    end
  end

  // All state registers; reset drops every in-flight tag and credit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_valid_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_idx_q   <= '0;
      res_valid_q <= '0;
      res_data_q  <= '0;
      for (int s = 0; s < ADD_LATENCY; s++) tag_q[s] <= '0;
      for (int i = 0; i < NREQ; i++)        cnt_q[i] <= '0;
    end else begin
      add_valid_q <= add_valid_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_idx_q   <= add_idx_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      for (int s = 0; s < ADD_LATENCY; s++) tag_q[s] <= tag_d[s];
      for (int i = 0; i < NREQ; i++)        cnt_q[i] <= cnt_d[i];
    end
  end

  // A returning result must always find an outstanding credit to release
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (rst_n && ret_vec[i] && !gnt[i]) assert (cnt_q[i] != '0);
    end
  end

  assign add_valid = add_valid_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_posit_add_arbiter.sv
// Directed bench for posit_add_arbiter: vector table plus multi-cycle sequences.
module tb_posit_add_arbiter;
  import posit_add_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = 4;
  localparam int MAXO = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*NBITS-1:0] req_a;
  logic [NREQ*NBITS-1:0] req_b;
  logic                  add_valid;
  logic [NBITS-1:0]      add_a;
  logic [NBITS-1:0]      add_b;
  logic [NBITS-1:0]      add_result;
  logic [NREQ-1:0]       res_valid;
  logic [NBITS-1:0]      res_data;
  logic                  busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  posit_add_arbiter #(
    .NREQ        (NREQ),
    .ADD_LATENCY (LAT),
    .MAX_OUT     (MAXO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .add_valid  (add_valid),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_result (add_result),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .busy       (busy)
  );

  // Stand-in adder: exact posit sums for the values used in the vectors,
  // a distinguishable operand mix otherwise (the arbiter never looks at contents).
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h8000_0000 || b == 32'h8000_0000) return 32'h8000_0000;
    if (a == 32'h0) return b;
    if (b == 32'h0) return a;
    if (a == 32'h4000_0000 && b == 32'h4000_0000) return 32'h4800_0000;
    if (a == 32'h4000_0000 && b == 32'h4800_0000) return 32'h4C00_0000;
    if (a == 32'h4000_0000 && b == 32'hC000_0000) return 32'h0000_0000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  // Adder pipeline: result visible LAT cycles after the cycle add_valid is high
  logic [31:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= add_valid ? ref_add(add_a, add_b) : (32'hDEAD_0000 | 32'(cyc[15:0]));
    for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
  end
  assign add_result = apipe[LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int i);
    return NREQ'(1) << i;
  endfunction

  // Scoreboard: every handshake expects its result LAT+2 cycles later at its requester
  typedef struct {
    int          idx;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sbq[$];

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sbq.delete();
    end else begin
      if (res_valid != '0 || (sbq.size() > 0 && sbq[0].due == cyc)) begin
        if (sbq.size() == 0) begin
          check("res_unexpected", 32'(res_valid), 32'h0);
        end else begin
          e = sbq.pop_front();
          check("res_cycle", 32'(cyc), 32'(e.due));
          check("res_route", 32'(res_valid), 32'(onehot(e.idx)));
          check("res_data", res_data, e.data);
        end
      end
      check("ready_onehot", 32'(req_ready & (req_ready - NREQ'(1))), 32'h0);
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.idx  = i;
          e.data = ref_add(req_a[i*NBITS +: NBITS], req_b[i*NBITS +: NBITS]);
          e.due  = cyc + LAT + 2;
          sbq.push_back(e);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*NBITS +: NBITS] = a;
    req_b[i*NBITS +: NBITS] = b;
  endtask

  task automatic drain();
    req_valid = '0;
    repeat (LAT + 6) next_cycle();
  endtask

  // Single requester held valid: 4 grants, 2 stalls, repeating; busy stays high
  task automatic run_credit(input int idx, input string tag);
    logic [13:0] pat;
    pat = 14'b11_0011_1100_1111;  // bit k = expected grant in cycle k
    next_cycle();
    set_op(idx, 32'h0100_0000 * (idx + 1), 32'h0000_0300);
    req_valid = onehot(idx);
    for (int k = 0; k < 14; k++) begin
      if (k > 0) next_cycle();
      #3;
      check({tag, "_ready"}, 32'(req_ready), pat[k] ? 32'(onehot(idx)) : 32'h0);
      if (k > 0) check({tag, "_busy"}, 32'(busy), 32'h1);
    end
    next_cycle();
    drain();
    #3;
    check({tag, "_busy_end"}, 32'(busy), 32'h0);
  endtask

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int gcount [NREQ];

    tbl[0] = '{0, 32'h4000_0000, 32'h4000_0000, 32'h4800_0000};  // 1+1=2
    tbl[1] = '{1, 32'h4000_0000, 32'h4800_0000, 32'h4C00_0000};  // 1+2=3
    tbl[2] = '{2, 32'h0000_0000, 32'h4000_0000, 32'h4000_0000};  // 0+1=1
    tbl[3] = '{3, 32'h8000_0000, 32'h4000_0000, 32'h8000_0000};  // NaR
    tbl[4] = '{1, 32'h4000_0000, 32'hC000_0000, 32'h0000_0000};  // 1+(-1)=0
    tbl[5] = '{3, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678};  // x+0=x

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    repeat (3) next_cycle();
    #3;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_add_valid", 32'(add_valid), 32'h0);
    check("rst_add_a", add_a, 32'h0);
    check("rst_add_b", add_b, 32'h0);
    check("rst_res_valid", 32'(res_valid), 32'h0);
    check("rst_res_data", res_data, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    next_cycle();
    rst_n = 1'b1;

    // Vector table: one isolated operation per entry
    for (int v = 0; v < 6; v++) begin
      next_cycle();
      set_op(tbl[v].idx, tbl[v].a, tbl[v].b);
      req_valid = onehot(tbl[v].idx);
      #3;
      check("tbl_ready", 32'(req_ready), 32'(onehot(tbl[v].idx)));
      check("tbl_busy_idle", 32'(busy), 32'h0);
      next_cycle();
      req_valid = '0;
      #3;
      check("tbl_add_valid", 32'(add_valid), 32'h1);
      check("tbl_add_a", add_a, tbl[v].a);
      check("tbl_add_b", add_b, tbl[v].b);
      check("tbl_busy", 32'(busy), 32'h1);
      lat = 1;
      while (lat < 20 && res_valid == '0) begin
        next_cycle();
        #3;
        lat++;
      end
      check("tbl_latency", 32'(lat), 32'(LAT + 2));
      check("tbl_res_valid", 32'(res_valid), 32'(onehot(tbl[v].idx)));
      check("tbl_res_data", res_data, tbl[v].exp);
      check("tbl_busy_done", 32'(busy), 32'h0);
      next_cycle();
      #3;
      check("tbl_res_clear", 32'(res_valid), 32'h0);
    end

    for (int i = 0; i < NREQ; i++) set_op(i, 32'h1111_0000 * (i + 1), 32'h0000_2222 * (i + 1));

`ifdef POSIT_ARB_FIXED_PRIO_EN
    begin
      int order [12] = '{0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 3, 1};
      next_cycle();
      req_valid = '1;
      for (int k = 0; k < 12; k++) begin
        if (k > 0) next_cycle();
        #3;
        check("prio_order", 32'(req_ready), 32'(onehot(order[k])));
      end
      next_cycle();
      drain();
    end
`else
    for (int i = 0; i < NREQ; i++) gcount[i] = 0;
    next_cycle();
    req_valid = '1;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) next_cycle();
      #3;
      check("fair_order", 32'(req_ready), 32'(onehot(k % NREQ)));
      if (k > 0) check("fair_add_valid", 32'(add_valid), 32'h1);
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) gcount[i]++;
    end
    next_cycle();
    req_valid = '0;
    #3;
    check("fair_last_issue", 32'(add_valid), 32'h1);
    for (int i = 0; i < NREQ; i++) check("fair_count", 32'(gcount[i]), 32'h4);
    drain();
`endif

    run_credit(2, "credit");
    run_credit(1, "samecyc");

    // Reset with three operations in flight
    next_cycle();
    req_valid = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) next_cycle();
      #3;
      check("mr_grant", 32'(|req_ready), 32'h1);
    end
    next_cycle();
    req_valid = '0;
    #3;
    check("mr_busy_before", 32'(busy), 32'h1);
    next_cycle();
    rst_n = 1'b0;
    #3;
    check("mr_busy_in_rst", 32'(busy), 32'h0);
    check("mr_add_valid_in_rst", 32'(add_valid), 32'h0);
    next_cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      #3;
      check("mr_no_result", 32'(res_valid), 32'h0);
      check("mr_busy_after", 32'(busy), 32'h0);
    end

    // Counters restarted: a fresh op goes through normally
    next_cycle();
    set_op(0, 32'h4000_0000, 32'h4000_0000);
    req_valid = 4'b0001;
    #3;
    check("post_rst_ready", 32'(req_ready), 32'h1);
    next_cycle();
    req_valid = '0;
    repeat (LAT + 4) next_cycle();
    #3;
    check("post_rst_busy", 32'(busy), 32'h0);
    check("sb_empty", 32'(sbq.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
